// File: rtl/sobel_window_3x3_if.sv
// Pixel-tap and result bundle for the 3x3 Sobel window stage.
// The master drives the three row taps; the slave returns tagged gradient results.
interface sobel_window_3x3_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_row0;
  logic [WIDTH-1:0] in_row1;
  logic [WIDTH-1:0] in_row2;
  logic             valid_in;
  logic             valid_out;
  logic [WIDTH-1:0] out_dout;
  logic             out_eol;
  logic             out_eof;

  modport master (
    output in_row0, in_row1, in_row2, valid_in,
    input  valid_out, out_dout, out_eol, out_eof
  );

  modport slave (
    input  in_row0, in_row1, in_row2, valid_in,
    output valid_out, out_dout, out_eol, out_eof
  );
endinterface

// File: rtl/sobel_window_3x3.sv
// 3x3 sliding window over three column-aligned row taps, followed by a 2-stage
// Sobel |Gx|+|Gy| pipeline with saturation and end-of-line/end-of-frame tags.
module sobel_window_3x3 #(
  parameter int WIDTH      = 8,
  parameter int IMG_WIDTH  = 6,
  parameter int IMG_HEIGHT = 6
) (
  input logic              clock,
  input logic              reset,
  sobel_window_3x3_if.slave bus
);

  localparam int SW    = WIDTH + 3;
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 3);
  localparam logic [SW-1:0]    MAX_PIX       = SW'((1 << WIDTH) - 1);

  // Row 0 is the top of the window (oldest line), row 2 the current line.
  logic [WIDTH-1:0] tap [3];
  logic [WIDTH-1:0] win [3][3];

  assign tap[0] = bus.in_row2;
  assign tap[1] = bus.in_row1;
  assign tap[2] = bus.in_row0;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [WIDTH-1:0] px_reg [3];

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          px_reg[0] <= '0;
          px_reg[1] <= '0;
          px_reg[2] <= '0;
        end else if (bus.valid_in) begin
          px_reg[0] <= px_reg[1];
          px_reg[1] <= px_reg[2];
          px_reg[2] <= tap[gi];
        end
      end

      assign win[gi][0] = px_reg[0];
      assign win[gi][1] = px_reg[1];
      assign win[gi][2] = px_reg[2];
    end
  endgenerate

  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic             win_valid_reg;
  logic             win_eol_reg;
  logic             win_eof_reg;

  // Tags are captured alongside the window so they reach the output with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_reg       <= '0;
      row_reg       <= '0;
      win_valid_reg <= 1'b0;
      win_eol_reg   <= 1'b0;
      win_eof_reg   <= 1'b0;
    end else begin
      win_valid_reg <= bus.valid_in && (col_reg >= COL_FIRST_WIN);
      win_eol_reg   <= bus.valid_in && (col_reg == COL_LAST);
      win_eof_reg   <= bus.valid_in && (col_reg == COL_LAST) && (row_reg == ROW_LAST);
      if (bus.valid_in) begin
        if (col_reg == COL_LAST) begin
          col_reg <= '0;
          row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
    end
  end

  function automatic logic signed [SW-1:0] ext(input logic [WIDTH-1:0] p);
    return $signed({3'b000, p});
  endfunction

  logic signed [SW-1:0] gx_next;
  logic signed [SW-1:0] gy_next;

  always_comb begin
    gx_next = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
            - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
    gy_next = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
            - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
  end

  logic signed [SW-1:0] gx_reg;
  logic signed [SW-1:0] gy_reg;
  logic                 s1_valid_reg;
  logic                 s1_eol_reg;
  logic                 s1_eof_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gx_reg       <= '0;
      gy_reg       <= '0;
      s1_valid_reg <= 1'b0;
      s1_eol_reg   <= 1'b0;
      s1_eof_reg   <= 1'b0;
    end else begin
      gx_reg       <= gx_next;
      gy_reg       <= gy_next;
      s1_valid_reg <= win_valid_reg;
      s1_eol_reg   <= win_eol_reg;
      s1_eof_reg   <= win_eof_reg;
    end
  end

  logic [SW-1:0]    abs_gx;
  logic [SW-1:0]    abs_gy;
  logic [SW-1:0]    mag;
  logic [WIDTH-1:0] dout_next;

  // Each magnitude is at most 4*(2^WIDTH-1), so the sum still fits in SW bits.
  always_comb begin
    abs_gx    = gx_reg[SW-1] ? $unsigned(-gx_reg) : $unsigned(gx_reg);
    abs_gy    = gy_reg[SW-1] ? $unsigned(-gy_reg) : $unsigned(gy_reg);
    mag       = abs_gx + abs_gy;
    dout_next = (mag > MAX_PIX) ? '1 : mag[WIDTH-1:0];
  end

  logic             valid_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             eol_reg;
  logic             eof_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      dout_reg  <= '0;
      eol_reg   <= 1'b0;
      eof_reg   <= 1'b0;
    end else begin
      valid_reg <= s1_valid_reg;
      dout_reg  <= dout_next;
      eol_reg   <= s1_eol_reg;
      eof_reg   <= s1_eof_reg;
    end
  end

  assign bus.valid_out = valid_reg;
  assign bus.out_dout  = dout_reg;
  assign bus.out_eol   = eol_reg;
  assign bus.out_eof   = eof_reg;

endmodule

// File: doc/sobel_window_3x3.md
Name: sobel_window_3x3

Overview:
- Consumer stage downstream of the two cascaded line buffers in the 3x3 filter path.
- Takes three row-aligned pixel taps per valid beat: current row, row-1 and row-2.
- Builds a 3x3 sliding window, computes the Sobel gradient magnitude |Gx|+|Gy| in a 2-stage pipeline, and emits one saturated result per fully interior window.
- Also tags end-of-line and end-of-frame on each result.

Parameters:
- WIDTH, 8, pixel and result width in bits.
- IMG_WIDTH, 6, pixels per line; must be >= 3.
- IMG_HEIGHT, 6, lines per frame; must be >= 3.

Ports:
- clock  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately, release is synchronous to clock.
- in_row0  input  WIDTH  pixel of current line r (bottom of window).
- in_row1  input  WIDTH  pixel of line r-1, from first line buffer.
- in_row2  input  WIDTH  pixel of line r-2, from second line buffer (top of window).
- valid_in  input  1  all three taps valid and column-aligned; one beat = one column.
- valid_out  output  1  out_dout/out_eol/out_eof valid this cycle.
- out_dout  output  WIDTH  saturated gradient magnitude.
- out_eol  output  1  result is last window of its line.
- out_eof  output  1  result is last window of the frame.

Behaviour:
- Reset (reset=0, async): window regs, counters, pipeline regs, valid_out, out_dout, out_eol, out_eof all 0.
- Window w[r][c], r=0 top (in_row2) .. r=2 bottom (in_row0), c=0 left/oldest .. c=2 right/newest.
- On edge with valid_in=1: each row shifts left (w[r][0]<=w[r][1], w[r][1]<=w[r][2], w[r][2]<=tap).
- valid_in=0: window and counters hold; pipeline still advances with valid=0 (bubble). No backpressure.
- col counter 0..IMG_WIDTH-1, increments per valid beat, wraps to 0 after IMG_WIDTH-1.
- row counter 0..IMG_HEIGHT-3, increments on col wrap, wraps to 0 after IMG_HEIGHT-3. Only IMG_HEIGHT-2 lines reach this stage per frame.
- Window valid: flagged when the beat is sampled with col >= 2. First two beats of each line produce no output, so no cross-line windows.
- eol flag = (col == IMG_WIDTH-1); eof flag = eol && (row == IMG_HEIGHT-3). Both travel with the window valid flag.
- Stage 1 (registered): Gx = (w02+2w12+w22)-(w00+2w10+w20); Gy = (w20+2w21+w22)-(w00+2w01+w02). Signed, WIDTH+3 bits each, no overflow.
- Stage 2 (registered): mag = |Gx|+|Gy| in WIDTH+3 bits unsigned. out_dout = mag if mag <= 2^WIDTH-1, else 2^WIDTH-1.
- Latency: taps presented in cycle t (sampled at end of t) give valid_out=1 in cycle t+3, high for exactly one cycle per window.
- Back-to-back valid_in gives one result per cycle.
- Outputs per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2) results, exactly one with out_eof=1 (the last).
- Frame boundary: counters wrap seamlessly; the next frame's first line again suppresses its first two outputs.
- Reset mid-frame: in-flight results discarded; after release, counting restarts at col=0,row=0.
- out_eol/out_eof are 0 whenever valid_out=0.

Test Plan:
- Uniform 6x6 frame, all taps=100, continuous valid_in -> 16 valid_out pulses, all out_dout=0; out_eol on pulses 4,8,12,16; out_eof only on pulse 16.
- Horizontal ramp (pixel=col on all rows) -> every result Gx=8, Gy=0, out_dout=8.
- Vertical edge: cols 0-2 = 0, cols 3-5 = 255 -> windows at col 3,4 give mag 1020, saturated to 255; window at col 5 gives 0.
- Random valid_in gaps (~50% duty) with ramp image -> identical result sequence to continuous case; each valid_out exactly 3 cycles after its sampling beat.
- Two frames back-to-back -> 32 results, out_eof on 16th and 32nd only; first two beats of frame 2 produce no output.
- Assert reset=0 mid-line 2, between edges -> outputs clear immediately without a clock edge; after release, a full frame gives 16 correct results.
